// File: rtl/audio_sample_fetch_pkg.sv
// Shared types and helpers for the audio sample fetch block.
// Holds the fetch FSM encoding, byte width and base-address stepping rules.
// No logic of its own; used by the fetch top, its packer and its interface.
package audio_fetch_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    NEXT = 2'd2,
    DONE = 2'd3
  } state_t;

  // Next sample base after one step; at an end it either wraps (loop) or holds.
  function automatic logic [31:0] next_base(input logic [31:0] base,
                                            input logic        dir,
                                            input logic [31:0] start,
                                            input logic [31:0] last,
                                            input logic        loop,
                                            input logic [31:0] step);
    logic [31:0] nb;
    if (dir) begin
      if (base < last) nb = base + step;
      else             nb = loop ? start : base;
    end else begin
      if (base > start) nb = base - step;
      else              nb = loop ? last : base;
    end
    return nb;
  endfunction

  // True when a step in direction dir would cross an end of the region.
  function automatic logic at_boundary(input logic [31:0] base,
                                       input logic        dir,
                                       input logic [31:0] start,
                                       input logic [31:0] last);
    return dir ? (base >= last) : (base <= start);
  endfunction

endpackage

// File: rtl/audio_sample_fetch_if.sv
// Flash byte-read channel between the sample fetcher and the flash read controller.
// Latency: n/a (wires only); rd_ack may come any number of cycles after rd_req.
// Backpressure: master holds rd_req and rd_addr stable until it samples rd_ack high.
interface audio_sample_fetch_if
  import audio_fetch_pkg::*;
#(
  parameter int unsigned ADDR_W = 23
);
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_ack;
  logic [BYTE_W-1:0] rd_data;

  modport master (output rd_req, output rd_addr, input rd_ack, input rd_data);
  modport slave  (input rd_req, input rd_addr, output rd_ack, output rd_data);
endinterface

// File: rtl/audio_sample_fetch_packer.sv
// sample_packer: BPS byte slots filled one at a time, read out little-endian.
// Latency: a loaded byte appears on pk_dat the cycle after load.
// Backpressure: none; clear wins over load.
module sample_packer
  import audio_fetch_pkg::*;
#(
  parameter int unsigned BPS   = 2,
  parameter int unsigned IDX_W = 1
) (
  input  logic                  clk,
  input  logic                  reset_all,
  input  logic                  clear,
  input  logic                  load,
  input  logic [IDX_W-1:0]      idx,
  input  logic [BYTE_W-1:0]     byte_in,
  output logic [BYTE_W*BPS-1:0] pk_dat
);

  logic [BYTE_W*BPS-1:0] slots_q;

  // Slot k holds byte k of the sample, i.e. bits [8k+7:8k].
  always_ff @(posedge clk or negedge reset_all) begin
    if (!reset_all) begin
      slots_q <= '0;
    end else if (clear) begin
      slots_q <= '0;
    end else if (load) begin
      for (int k = 0; k < int'(BPS); k++) begin
        if (idx == IDX_W'(k)) slots_q[k*BYTE_W +: BYTE_W] <= byte_in;
      end
    end
  end

  assign pk_dat = slots_q;

endmodule

// File: rtl/audio_sample_fetch.sv
// audio_sample_fetch: per sample_tick fetch BPS flash bytes, pack little-endian, step base fwd/rev (AUDIO_FETCH_LOOP_EN: wrap at ends, else halt).
// Latency: tick -> sample_valid after 2*BPS cycles with zero-wait flash; every flash wait cycle adds one.
// Backpressure: rd_req holds until rd_ack; ticks that arrive while busy are dropped and flagged on overrun.
module audio_sample_fetch
  import audio_fetch_pkg::*;
#(
  parameter int unsigned ADDR_W     = 23,
  parameter int unsigned BPS        = 2,
  parameter int unsigned START_ADDR = 0,
  parameter int unsigned END_ADDR   = 32'h7FFFF
) (
  input  logic                  clk,
  input  logic                  reset_all,
  input  logic                  sample_tick,
  input  logic                  play_en,
  input  logic                  dir,
  input  logic                  restart,
  audio_sample_fetch_if.master  rd,
  output logic [BYTE_W*BPS-1:0] sample_out,
  output logic                  sample_valid,
  output logic                  busy,
  output logic                  at_end,
  output logic                  overrun
);

  localparam int unsigned LAST_BASE = END_ADDR - BPS + 1;
  localparam int unsigned IDX_W     = (BPS > 1) ? $clog2(BPS) : 1;
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(BPS - 1);
  localparam logic [ADDR_W-1:0] START_A  = ADDR_W'(START_ADDR);
  localparam logic [ADDR_W-1:0] LAST_A   = ADDR_W'(LAST_BASE);
`ifdef AUDIO_FETCH_LOOP_EN
  localparam logic LOOP = 1'b1;
`else
  localparam logic LOOP = 1'b0;
`endif

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [ADDR_W-1:0]     base_q, base_d;
  logic [ADDR_W-1:0]     rd_addr_q, rd_addr_d;
  logic [BYTE_W*BPS-1:0] sample_q, sample_d;
  logic                  at_end_q, at_end_d;
  logic                  abort_q, abort_d;
  logic                  overrun_q, overrun_d;

  logic                  accept;
  logic                  away;
  logic                  rd_req_c, busy_c, valid_c, pk_clear, pk_load;
  logic [BYTE_W*BPS-1:0] pk_dat;

  // restart outranks a same-cycle tick; a halted block ignores ticks.
  assign accept = sample_tick & play_en & ~at_end_q & ~restart;
  // Direction now points back into the region from the end we halted at.
  assign away   = (dir & (base_q == START_A)) | (~dir & (base_q == LAST_A));

  // State register
  always_ff @(posedge clk or negedge reset_all) begin
    if (!reset_all) state_q <= IDLE;
    else            state_q <= state_d;
  end

  // Next state: an aborted fetch still waits for rd_ack before going idle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = REQ;
      REQ: begin
        if (rd.rd_ack) begin
          if (abort_q || restart)  state_d = IDLE;
          else if (idx_q == IDX_LAST) state_d = DONE;
          else                     state_d = NEXT;
        end
      end
      NEXT:    state_d = restart ? IDLE : REQ;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs decoded from the current state.
  always_comb begin
    rd_req_c = (state_q == REQ);
    busy_c   = (state_q != IDLE);
    valid_c  = (state_q == DONE);
    pk_clear = (state_q == IDLE) && accept;
    pk_load  = (state_q == REQ) && rd.rd_ack;
  end

  // Datapath next values: byte index, address, base stepping and flags.
  always_comb begin
    idx_d     = idx_q;
    base_d    = base_q;
    rd_addr_d = rd_addr_q;
    sample_d  = sample_q;
    at_end_d  = at_end_q;
    abort_d   = 1'b0;
    overrun_d = sample_tick & play_en & busy_c & ~restart;

    if (state_q == IDLE) idx_d = '0;
    if (state_q == NEXT) idx_d = idx_q + 1'b1;
    if (state_q == REQ)  abort_d = ~rd.rd_ack & (abort_q | restart);
    // Latch the address on REQ entry so base may change under a pending fetch.
    if ((state_d == REQ) && (state_q != REQ)) rd_addr_d = base_q + ADDR_W'(idx_d);
    if (state_q == DONE) sample_d = pk_dat;

    if (restart) begin
      base_d   = dir ? START_A : LAST_A;
      at_end_d = 1'b0;
    end else if (state_q == DONE) begin
      base_d = ADDR_W'(next_base(32'(base_q), dir, START_ADDR, LAST_BASE, LOOP, BPS));
      if (!LOOP && at_boundary(32'(base_q), dir, START_ADDR, LAST_BASE)) at_end_d = 1'b1;
    end else if (at_end_q && away) begin
      at_end_d = 1'b0;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge reset_all) begin
    if (!reset_all) begin
      idx_q     <= '0;
      base_q    <= START_A;
      rd_addr_q <= START_A;
      sample_q  <= '0;
      at_end_q  <= 1'b0;
      abort_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      idx_q     <= idx_d;
      base_q    <= base_d;
      rd_addr_q <= rd_addr_d;
      sample_q  <= sample_d;
      at_end_q  <= at_end_d;
      abort_q   <= abort_d;
      overrun_q <= overrun_d;
    end
  end

  sample_packer #(
    .BPS   (BPS),
    .IDX_W (IDX_W)
  ) u_packer (
    .clk       (clk),
    .reset_all (reset_all),
    .clear     (pk_clear),
    .load      (pk_load),
    .idx       (idx_q),
    .byte_in   (rd.rd_data),
    .pk_dat    (pk_dat)
  );

  assign rd.rd_req    = rd_req_c;
  assign rd.rd_addr   = rd_addr_q;
  // The fresh sample is shown during DONE itself so it lines up with sample_valid.
  assign sample_out   = valid_c ? pk_dat : sample_q;
  assign sample_valid = valid_c;
  assign busy         = busy_c;
  assign overrun      = overrun_q;
`ifdef AUDIO_FETCH_LOOP_EN
  assign at_end       = 1'b0;
`else
  assign at_end       = at_end_q;
`endif

endmodule
